// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down counter with parallel load, optional wrap, terminal-count
// pulse and rejected-load flag. One bcd_digit slice per digit forms the borrow chain.

module bcd_digit (
  input  logic [3:0] d,
  input  logic       bin,
  input  logic [3:0] ld,
  output logic [3:0] dn,
  output logic       bout,
  output logic       ld_ok
);
  assign bout  = bin && (d == 4'd0);
  assign dn    = !bin ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
  assign ld_ok = (ld <= 4'd9);
endmodule

module bcd_down_counter #(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned WRAP       = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  input  logic                    en,
  output logic [4*NUM_DIGITS-1:0] q,
  output logic                    zero,
  output logic                    tc,
  output logic                    busy,
  output logic                    load_err
);
  localparam int unsigned W = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                state, state_nxt;
  logic [NUM_DIGITS:0]   borrow;
  logic [NUM_DIGITS-1:0] ld_ok;
  logic [W-1:0]          q_dec, q_nxt;
  logic                  tc_nxt, lerr_nxt;
  logic                  load_good, count_step, hit_zero;

  assign borrow[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      bcd_digit u_dig (
        .d    (q[4*g +: 4]),
        .bin  (borrow[g]),
        .ld   (load_val[4*g +: 4]),
        .dn   (q_dec[4*g +: 4]),
        .bout (borrow[g+1]),
        .ld_ok(ld_ok[g])
      );
    end
  endgenerate

  // A borrow that survives every digit means all digits are 0; decrementing
  // 0 through the chain yields all-9s, which is exactly the wrap reload.
  assign zero       = borrow[NUM_DIGITS];
  assign load_good  = &ld_ok;
  assign count_step = en && (state == RUN) && (!zero || (WRAP != 0));
  assign hit_zero   = !zero && (q_dec == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else if (load) begin
      if (load_good)
        state_nxt = ((load_val == '0) && (WRAP == 0)) ? DONE : RUN;
    end else if (count_step && hit_zero && (WRAP == 0)) begin
      state_nxt = DONE;
    end
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_comb begin
    q_nxt    = q;
    tc_nxt   = 1'b0;
    lerr_nxt = 1'b0;
    if (clr) begin
      q_nxt = '0;
    end else if (load) begin
      if (load_good) q_nxt    = load_val;
      else           lerr_nxt = 1'b1;
    end else if (count_step) begin
      q_nxt  = q_dec;
      tc_nxt = hit_zero;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q        <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      q        <= q_nxt;
      tc       <= tc_nxt;
      load_err <= lerr_nxt;
    end
  end
endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for bcd_down_counter: three instances (2-digit stop, 2-digit wrap,
// 3-digit stop) checked through an expected-value queue.

module tb_bcd_down_counter;
  typedef struct packed {
    logic [11:0] q;
    logic        zero;
    logic        tc;
    logic        busy;
    logic        lerr;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        a_clr, a_load, a_en, a_zero, a_tc, a_busy, a_lerr;
  logic [7:0]  a_lv, a_q;
  logic        b_clr, b_load, b_en, b_zero, b_tc, b_busy, b_lerr;
  logic [7:0]  b_lv, b_q;
  logic        c_clr, c_load, c_en, c_zero, c_tc, c_busy, c_lerr;
  logic [11:0] c_lv, c_q;

  bcd_down_counter #(.NUM_DIGITS(2), .WRAP(0)) u_a (
    .clk(clk), .reset_n(reset_n), .clr(a_clr), .load(a_load), .load_val(a_lv),
    .en(a_en), .q(a_q), .zero(a_zero), .tc(a_tc), .busy(a_busy), .load_err(a_lerr));
  bcd_down_counter #(.NUM_DIGITS(2), .WRAP(1)) u_b (
    .clk(clk), .reset_n(reset_n), .clr(b_clr), .load(b_load), .load_val(b_lv),
    .en(b_en), .q(b_q), .zero(b_zero), .tc(b_tc), .busy(b_busy), .load_err(b_lerr));
  bcd_down_counter #(.NUM_DIGITS(3), .WRAP(0)) u_c (
    .clk(clk), .reset_n(reset_n), .clr(c_clr), .load(c_load), .load_val(c_lv),
    .en(c_en), .q(c_q), .zero(c_zero), .tc(c_tc), .busy(c_busy), .load_err(c_lerr));

  obs_t  exp_q[$];
  string tag_q[$];
  int    sel_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic logic [11:0] bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic obs_t get_obs(int sel);
    obs_t o;
    case (sel)
      0:       o = '{q: {4'h0, a_q}, zero: a_zero, tc: a_tc, busy: a_busy, lerr: a_lerr};
      1:       o = '{q: {4'h0, b_q}, zero: b_zero, tc: b_tc, busy: b_busy, lerr: b_lerr};
      default: o = '{q: c_q, zero: c_zero, tc: c_tc, busy: c_busy, lerr: c_lerr};
    endcase
    return o;
  endfunction

  task automatic drive(int sel, logic c, logic l, logic e, logic [11:0] lv);
    {a_clr, a_load, a_en, a_lv} = '0;
    {b_clr, b_load, b_en, b_lv} = '0;
    {c_clr, c_load, c_en, c_lv} = '0;
    case (sel)
      0:       begin a_clr = c; a_load = l; a_en = e; a_lv = lv[7:0]; end
      1:       begin b_clr = c; b_load = l; b_en = e; b_lv = lv[7:0]; end
      default: begin c_clr = c; c_load = l; c_en = e; c_lv = lv;      end
    endcase
  endtask

  task automatic push(int sel, string tag, logic [11:0] q, logic tc, logic busy, logic lerr);
    obs_t e;
    e = '{q: q, zero: (q == 12'h000), tc: tc, busy: busy, lerr: lerr};
    exp_q.push_back(e);
    tag_q.push_back(tag);
    sel_q.push_back(sel);
  endtask

  task automatic check_pop();
    obs_t  e, o;
    string t;
    int    s;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    s = sel_q.pop_front();
    o = get_obs(s);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: got q=%h zero=%b tc=%b busy=%b lerr=%b, want q=%h zero=%b tc=%b busy=%b lerr=%b",
             t, o.q, o.zero, o.tc, o.busy, o.lerr, e.q, e.zero, e.tc, e.busy, e.lerr);
    end
  endtask

  // One clocked step: drive after the falling edge, check 1 time unit past the rising edge.
  task automatic step(int sel, logic c, logic l, logic e, logic [11:0] lv, string tag,
                      logic [11:0] q, logic tc, logic busy, logic lerr);
    @(negedge clk);
    drive(sel, c, l, e, lv);
    push(sel, tag, q, tc, busy, lerr);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 1'b0, 12'h000);
    reset_n = 1'b0;
    #12;
    push(0, "reset_a", 12'h000, 1'b0, 1'b0, 1'b0); check_pop();
    push(2, "reset_c", 12'h000, 1'b0, 1'b0, 1'b0); check_pop();
    @(negedge clk);
    reset_n = 1'b1;

    step(0, 0, 0, 1, 12'h000, "en_in_idle", 12'h000, 0, 0, 0);

    // async reset mid-count
    step(0, 0, 1, 0, 12'h037, "load_37", 12'h037, 0, 1, 0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b1, 12'h000);
    #2;
    reset_n = 1'b0;
    #1;
    push(0, "async_reset", 12'h000, 1'b0, 1'b0, 1'b0); check_pop();
    @(negedge clk);
    reset_n = 1'b1;

    // countdown from 12 to DONE
    step(0, 0, 1, 1, 12'h012, "load_12", 12'h012, 0, 1, 0);
    for (int v = 11; v >= 1; v--)
      step(0, 0, 0, 1, 12'h000, $sformatf("cnt_%0d", v), bcd(v), 0, 1, 0);
    step(0, 0, 0, 1, 12'h000, "cnt_0_tc", 12'h000, 1, 0, 0);
    step(0, 0, 0, 1, 12'h000, "done_hold1", 12'h000, 0, 0, 0);
    step(0, 0, 0, 1, 12'h000, "done_hold2", 12'h000, 0, 0, 0);

    // wrap
    step(1, 0, 1, 0, 12'h001, "w_load_01", 12'h001, 0, 1, 0);
    step(1, 0, 0, 1, 12'h000, "w_to_00",   12'h000, 1, 1, 0);
    step(1, 0, 0, 1, 12'h000, "w_to_99",   12'h099, 0, 1, 0);
    step(1, 0, 0, 1, 12'h000, "w_to_98",   12'h098, 0, 1, 0);
    step(1, 0, 0, 0, 12'h000, "w_hold",    12'h098, 0, 1, 0);

    // full borrow ripple across three digits
    step(2, 0, 1, 0, 12'h100, "c_load_100", 12'h100, 0, 1, 0);
    step(2, 0, 0, 1, 12'h000, "c_to_099",   12'h099, 0, 1, 0);
    step(2, 0, 1, 1, 12'h9A0, "c_bad_mid",  12'h099, 0, 1, 1);
    step(2, 0, 1, 0, 12'hA00, "c_bad_top",  12'h099, 0, 1, 1);
    step(2, 0, 0, 0, 12'h000, "c_lerr_off", 12'h099, 0, 1, 0);

    // rejected load then load with en
    step(0, 0, 1, 0, 12'h045, "load_45",    12'h045, 0, 1, 0);
    step(0, 0, 1, 1, 12'h04A, "bad_4A",     12'h045, 0, 1, 1);
    step(0, 0, 0, 0, 12'h000, "lerr_pulse", 12'h045, 0, 1, 0);
    step(0, 0, 1, 1, 12'h030, "load_30_en", 12'h030, 0, 1, 0);
    step(0, 0, 0, 1, 12'h000, "cnt_29",     12'h029, 0, 1, 0);

    // clr beats load and en
    step(0, 0, 1, 0, 12'h020, "load_20",  12'h020, 0, 1, 0);
    step(0, 1, 1, 1, 12'h055, "clr_all",  12'h000, 0, 0, 0);
    step(0, 0, 0, 1, 12'h000, "idle_en1", 12'h000, 0, 0, 0);
    step(0, 0, 0, 1, 12'h000, "idle_en2", 12'h000, 0, 0, 0);

    // load of 0 without wrap goes straight to DONE, no tc
    step(0, 0, 1, 1, 12'h000, "load_00",   12'h000, 0, 0, 0);
    step(0, 0, 0, 1, 12'h000, "done_en",   12'h000, 0, 0, 0);
    step(0, 0, 1, 0, 12'h099, "load_99",   12'h099, 0, 1, 0);
    step(0, 0, 0, 1, 12'h000, "cnt_98",    12'h098, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
